// File: rtl/dshot_pkg.sv
// Shared DShot definitions: mode codes, frame length, bit-rate table and CRC.
package dshot_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        MODE_DSHOT150  = 2'd0,
        MODE_DSHOT300  = 2'd1,
        MODE_DSHOT600  = 2'd2,
        MODE_DSHOT1200 = 2'd3
    } dshot_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BIT,
        ST_GAP
    } tx_state_e;

    // Bit rate in kbit/s for each mode code.
    function automatic int rate_kbps(input logic [1:0] mode);
        case (mode)
            MODE_DSHOT150: return 150;
            MODE_DSHOT300: return 300;
            MODE_DSHOT600: return 600;
            default:       return 1200;
        endcase
    endfunction

    // Clock cycles per DShot bit, truncated.
    function automatic int bit_cycles(input int clk_hz, input logic [1:0] mode);
        return clk_hz / (rate_kbps(mode) * 1000);
    endfunction

    // DShot checksum: XOR of the three nibbles of {throttle, telem}.
    function automatic logic [3:0] dshot_crc(input logic [11:0] v12);
        return v12[3:0] ^ v12[7:4] ^ v12[11:8];
    endfunction

endpackage

// File: rtl/dshot_frame_builder.sv
// Builds one 16-bit DShot frame {throttle, telem, crc} for a single channel.
module dshot_frame_builder
    import dshot_pkg::*;
(
    input  logic [10:0]           throttle_i,
    input  logic                  telem_i,
    output logic [FRAME_BITS-1:0] frame_o
);

    logic [11:0] v12;

    assign v12     = {throttle_i, telem_i};
    assign frame_o = {v12, dshot_crc(v12)};

endmodule

// File: rtl/dshot_tx_multi.sv
// Multi-channel DShot transmitter: one shared bit timer drives all channels
// bit-aligned, each channel carrying its own latched frame.
module dshot_tx_multi
    import dshot_pkg::*;
#(
    parameter int NUM_MOTORS = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int GAP_BITS   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [1:0]               i_mode,
    input  logic [NUM_MOTORS*11-1:0] i_throttle,
    input  logic [NUM_MOTORS-1:0]    i_telem,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [NUM_MOTORS-1:0]    o_motor,
    output logic                     o_busy
);

    localparam int BC_0  = bit_cycles(CLK_HZ, 2'd0);
    localparam int BC_1  = bit_cycles(CLK_HZ, 2'd1);
    localparam int BC_2  = bit_cycles(CLK_HZ, 2'd2);
    localparam int BC_3  = bit_cycles(CLK_HZ, 2'd3);
    // DShot150 has the longest bit, so its period sizes every counter.
    localparam int CW    = $clog2(BC_0 + 1);
    localparam int IW    = ($clog2(GAP_BITS) > 4) ? $clog2(GAP_BITS) : 4;
    localparam logic [IW-1:0] LAST_BIT = IW'(FRAME_BITS - 1);
    localparam logic [IW-1:0] GAP_LAST = IW'(GAP_BITS - 1);

    tx_state_e               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           bc_q, t1h_q, t0h_q;
    logic [CW-1:0]           bc_sel, t1h_sel, t0h_sel;
    logic                    ready_q;
    logic [NUM_MOTORS-1:0]   motor_q, motor_d;
    logic                    accept;
    logic                    bit_end;

    assign accept  = i_valid && ready_q;
    assign bit_end = (cnt_q == bc_q - CW'(1));
    assign o_ready = ready_q;
    assign o_busy  = !ready_q;
    assign o_motor = motor_q;

    // Timing constants for the requested mode, captured only on accept.
    always_comb begin
        bc_sel  = CW'(BC_0);
        t1h_sel = CW'(BC_0 * 3 / 4);
        t0h_sel = CW'(BC_0 * 3 / 8);
        case (i_mode)
            2'd1: begin
                bc_sel  = CW'(BC_1);
                t1h_sel = CW'(BC_1 * 3 / 4);
                t0h_sel = CW'(BC_1 * 3 / 8);
            end
            2'd2: begin
                bc_sel  = CW'(BC_2);
                t1h_sel = CW'(BC_2 * 3 / 4);
                t0h_sel = CW'(BC_2 * 3 / 8);
            end
            2'd3: begin
                bc_sel  = CW'(BC_3);
                t1h_sel = CW'(BC_3 * 3 / 4);
                t0h_sel = CW'(BC_3 * 3 / 8);
            end
            default: ;
        endcase
    end

    // Next-state logic: walk 16 data bits, then GAP_BITS silent bit periods.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BIT;
                    idx_d   = LAST_BIT;
                    cnt_d   = '0;
                end
            end
            ST_BIT: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = ST_GAP;
                        idx_d   = GAP_LAST;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, shared timer, latched timing and registered line outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bc_q    <= '0;
            t1h_q   <= '0;
            t0h_q   <= '0;
            ready_q <= 1'b0;
            motor_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (accept) begin
                bc_q  <= bc_sel;
                t1h_q <= t1h_sel;
                t0h_q <= t0h_sel;
            end
            ready_q <= (state_d == ST_IDLE);
            motor_q <= motor_d;
        end
    end

    for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_ch
        logic [FRAME_BITS-1:0] frame_d;
        logic [FRAME_BITS-1:0] frame_q;
        logic [CW-1:0]         high_len;

        dshot_frame_builder u_builder (
            .throttle_i (i_throttle[11*gi +: 11]),
            .telem_i    (i_telem[gi]),
            .frame_o    (frame_d)
        );

        // Frame is captured together with the timing on accept.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                frame_q <= '0;
            end else if (accept) begin
                frame_q <= frame_d;
            end
        end

        assign high_len   = frame_q[idx_q[3:0]] ? t1h_q : t0h_q;
        assign motor_d[gi] = (state_q == ST_BIT) && (cnt_q < high_len);
    end

endmodule

// File: tb/tb_dshot_tx_multi.sv
// Self-checking bench for dshot_tx_multi: a waveform-queue model checked
// every cycle, plus pulse-decoded frames and timings against literals.
module tb_dshot_tx_multi;

    localparam int NM     = 4;
    localparam int CLK_HZ = 50000000;
    localparam int GAP    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = 2'd0;
    logic [NM*11-1:0]  thr = '0;
    logic [NM-1:0]     tel = '0;
    logic              valid = 1'b0;
    logic              ready;
    logic              busy;
    logic [NM-1:0]     motor;

    always #10 clk = ~clk;

    dshot_tx_multi #(.NUM_MOTORS(NM), .CLK_HZ(CLK_HZ), .GAP_BITS(GAP)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_mode     (mode),
        .i_throttle (thr),
        .i_telem    (tel),
        .i_valid    (valid),
        .o_ready    (ready),
        .o_motor    (motor),
        .o_busy     (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_bc(input int md);
        int r [4] = '{150, 300, 600, 1200};
        return CLK_HZ / (r[md] * 1000);
    endfunction

    function automatic logic [15:0] m_frame(input int thr_v, input int tel_v);
        int v = thr_v * 2 + tel_v;
        int c = 0;
        for (int n = 0; n < 3; n++) c = c ^ ((v >> (4 * n)) & 15);
        return 16'(v * 16 + c);
    endfunction

    logic [NM-1:0] exp_q [$];
    logic [NM-1:0] exp_motor = '0;
    bit            exp_ready = 1'b0;
    bit            model_ok  = 1'b0;

    // Model: each accept queues the full per-cycle line waveform of frame + gap.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                exp_motor = '0;
                exp_ready = 1'b0;
            end else begin
                bit acc;
                acc = exp_ready && valid;
                exp_motor = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                if (acc) begin
                    logic [15:0] fr [NM];
                    int bc, t1, t0;
                    bc = m_bc(int'(mode));
                    t1 = bc * 3 / 4;
                    t0 = bc * 3 / 8;
                    for (int k = 0; k < NM; k++)
                        fr[k] = m_frame(int'(thr[11*k +: 11]), int'(tel[k]));
                    for (int b = 15; b >= 0; b--) begin
                        for (int c = 0; c < bc; c++) begin
                            logic [NM-1:0] vec;
                            for (int k = 0; k < NM; k++)
                                vec[k] = (c < (fr[k][b] ? t1 : t0));
                            exp_q.push_back(vec);
                        end
                    end
                    for (int c = 0; c < GAP * bc; c++) exp_q.push_back('0);
                end
                exp_ready = (exp_q.size() == 0);
            end
            model_ok = 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("cyc_motor", motor, exp_motor);
                check("cyc_ready", ready, exp_ready);
                check("cyc_busy", busy, !exp_ready);
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------
    logic [15:0] cap_frame [NM];
    int          cap_hi [NM];
    int          rlow;

    task automatic send(input int md, input int t0, input int t1, input int t2,
                        input int t3, input logic [3:0] tl);
        @(negedge clk);
        mode  = 2'(md);
        thr   = {11'(t3), 11'(t2), 11'(t1), 11'(t0)};
        tel   = tl;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Decode each line's pulse widths into frame bits (long high = 1).
    task automatic capture(input int bc);
        int run [NM];
        int nb [NM];
        for (int k = 0; k < NM; k++) begin
            run[k] = 0; nb[k] = 0; cap_frame[k] = '0; cap_hi[k] = 0;
        end
        rlow = 0;
        for (int t = 0; t < 16 * bc + 2; t++) begin
            @(negedge clk);
            if (!ready) rlow++;
            for (int k = 0; k < NM; k++) begin
                if (motor[k]) begin
                    run[k]++;
                end else if (run[k] > 0) begin
                    cap_frame[k] = {cap_frame[k][14:0], (run[k] * 2 > bc)};
                    if (nb[k] == 0) cap_hi[k] = run[k];
                    nb[k]++;
                    run[k] = 0;
                end
            end
        end
    endtask

    task automatic wait_ready(input int budget);
        int t = 0;
        while (t < budget) begin
            @(negedge clk);
            if (ready) break;
            rlow++;
            t++;
        end
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int starts [$];
        int lowrun;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 1);
        check("rst_motor", motor, 0);
        rst = 1'b0;
        @(negedge clk);
        check("release_ready", ready, 1);

        // Literal pins of the model's arithmetic
        check("pin_model_bc_m2", m_bc(2), 83);
        check("pin_model_frame", m_frame(1046, 0), 16'h82C6);

        // DShot600, four distinct channels
        send(2, 1046, 48, 0, 2047, 4'b1010);
        capture(83);
        check("m2_frame_ch0", cap_frame[0], 16'h82C6);
        check("m2_frame_ch1", cap_frame[1], 16'h0617);
        check("m2_frame_ch2", cap_frame[2], 16'h0000);
        check("m2_frame_ch3", cap_frame[3], 16'hFFFF);
        check("m2_t1h", cap_hi[0], 62);
        check("m2_t0h", cap_hi[2], 31);
        wait_ready(400);
        check("m2_ready_low", rlow, 18 * 83);

        // Mid-frame valid pulse, mode and data change must be ignored
        send(2, 300, 1000, 5, 777, 4'b0001);
        fork
            capture(83);
            begin
                repeat (400) @(negedge clk);
                valid = 1'b1; mode = 2'd0; thr = '1; tel = '1;
                @(negedge clk);
                valid = 1'b0; mode = 2'd2;
            end
        join
        check("ign_frame_ch0", cap_frame[0], 16'h259E);
        check("ign_frame_ch1", cap_frame[1], 16'h7D0A);
        wait_ready(400);
        check("ign_ready_low", rlow, 18 * 83);

        // DShot150
        send(0, 1046, 48, 0, 2047, 4'b1010);
        capture(333);
        check("m0_frame_ch0", cap_frame[0], 16'h82C6);
        check("m0_t1h", cap_hi[0], 249);
        check("m0_t0h", cap_hi[2], 124);
        wait_ready(1500);
        check("m0_ready_low", rlow, 18 * 333);

        // DShot1200
        send(3, 1046, 48, 0, 2047, 4'b1010);
        capture(41);
        check("m3_frame_ch1", cap_frame[1], 16'h0617);
        check("m3_frame_ch3", cap_frame[3], 16'hFFFF);
        check("m3_t1h", cap_hi[0], 30);
        check("m3_t0h", cap_hi[2], 15);
        wait_ready(300);
        check("m3_ready_low", rlow, 18 * 41);

        // i_valid held high: back-to-back frames
        @(negedge clk);
        mode = 2'd2; thr = {11'd9, 11'd200, 11'd48, 11'd1046}; tel = 4'b0000; valid = 1'b1;
        lowrun = 1000;
        for (int t = 0; t < 2 * (18 * 83 + 1) + 40; t++) begin
            @(negedge clk);
            if (motor[0]) begin
                if (lowrun >= 83) starts.push_back(t);
                lowrun = 0;
            end else begin
                lowrun++;
            end
        end
        valid = 1'b0;
        if (starts.size() < 3) begin
            check("b2b_frame_count", starts.size(), 3);
        end else begin
            check("b2b_spacing1", starts[1] - starts[0], 18 * 83 + 1);
            check("b2b_spacing2", starts[2] - starts[1], 18 * 83 + 1);
        end
        wait_ready(3200);

        // Reset asserted during bit 7
        send(2, 1046, 48, 0, 2047, 4'b1010);
        repeat ((15 - 7) * 83 + 10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_motor", motor, 0);
        check("midrst_ready", ready, 0);
        check("midrst_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_release_ready", ready, 1);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dshot_tx_multi.md
DSHOT_TX_MULTI -- requirements
Module: dshot_tx_multi

Interface
REQ-001 Parameter NUM_MOTORS, default 4, number of DShot output channels (1..8).
REQ-002 Parameter CLK_HZ, default 50000000, i_clk frequency in Hz.
REQ-003 Parameter GAP_BITS, default 2, inter-frame low gap in bit periods (>=1).
REQ-004 Port i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port i_reset  input  1  synchronous, active-high reset.
REQ-006 Port i_mode  input  2  0=DShot150, 1=DShot300, 2=DShot600, 3=DShot1200.
REQ-007 Port i_throttle  input  NUM_MOTORS*11  11-bit value per channel; channel k at bits [11k+10:11k].
REQ-008 Port i_telem  input  NUM_MOTORS  telemetry-request bit per channel.
REQ-009 Port i_valid  input  1  command word valid.
REQ-010 Port o_ready  output  1  block can accept a command.
REQ-011 Port o_motor  output  NUM_MOTORS  DShot line per channel.
REQ-012 Port o_busy  output  1  frame or gap in progress; equals !o_ready.

Function
REQ-013 Accept occurs on a rising edge with i_valid=1 and o_ready=1; i_throttle, i_telem and i_mode are latched on that edge only.
REQ-014 Per channel: v12 = {throttle[10:0], telem}; crc = (v12 ^ (v12>>4) ^ (v12>>8)) & 4'hF; frame = {v12, crc}, 16 bits.
REQ-015 BIT_CYC = CLK_HZ/(rate_kbps*1000) with integer truncation (150/300/600/1200); T1H = BIT_CYC*3/4; T0H = BIT_CYC*3/8, all truncated.
REQ-016 Counter widths sized by $clog2 of the DShot150 BIT_CYC; no overflow permitted in any mode.
REQ-017 FSM states: IDLE, BIT, GAP.
REQ-018 IDLE: o_ready=1, o_motor all 0; accept -> BIT with bit index 15, cycle counter 0.
REQ-019 BIT: frames sent MSB first; all channels bit-aligned; line high for cycles 0..TxH-1 of each bit, low for TxH..BIT_CYC-1; after bit 0 completes -> GAP.
REQ-020 First high cycle of bit 15 appears on the edge after the accepting edge (latency 1).
REQ-021 GAP: o_motor 0 for GAP_BITS*BIT_CYC cycles, then -> IDLE; o_ready rises exactly (16+GAP_BITS)*BIT_CYC+1 edges after accept.
REQ-022 i_valid and i_mode changes while not in IDLE are ignored; no queuing, no abort.
REQ-023 i_valid held high continuously yields back-to-back frames separated only by the gap plus one IDLE cycle.
REQ-024 Throttle values 0..47 are transmitted unmodified (special commands are the host's concern).
REQ-025 o_motor is registered; glitch-free, no combinational path from inputs.

Reset
REQ-026 While i_reset=1 on an edge: state IDLE, o_motor=0, o_ready=0, o_busy=1, counters and frame registers 0.
REQ-027 First edge with i_reset=0 enters IDLE with o_ready=1; reset asserted mid-frame truncates the frame, lines low on the next edge.

Structure
REQ-028 Shared package/include dshot_pkg holds mode codes, FRAME_BITS=16, rate table {150,300,600,1200} and the CRC function.
REQ-029 One sub-module dshot_frame_builder (throttle, telem -> 16-bit frame) instantiated per channel; timing counters shared across channels.

Verification
REQ-030 CLK_HZ=50e6, mode 2, ch0 throttle 1046 telem 0 -> frame 0x82C6; BIT_CYC 83, '1' high 62 cycles, '0' high 31 cycles.
REQ-031 Throttle 48 telem 1 -> frame 0x0617; throttle 0 telem 0 -> 0x0000 (16 bits of 31-cycle highs in mode 2).
REQ-032 Mode 0 vs mode 3 single accept -> BIT_CYC 333/41, T1H 249/30, T0H 124/15; o_ready returns after (18*BIT_CYC)+1 edges.
REQ-033 4 channels with distinct throttles accepted together -> all rising edges coincident, each line carries its own CRC-correct frame.
REQ-034 i_valid pulsed and i_mode changed mid-frame -> ignored, frame unchanged; i_valid held high -> consecutive frames with exactly GAP_BITS*BIT_CYC+1 low cycles between.
REQ-035 i_reset asserted at bit 7 -> o_motor 0 next edge, o_ready 0 during reset, 1 on first edge after release.
